// File: rtl/tx_symbol_serializer_if.sv
// Symbol handshake between the 8b/10b encoder (master) and the lane
// serializer (slave). A symbol moves when symbol_valid_i and symbol_ready_o
// are both high on a rising clock edge.
interface tx_symbol_serializer_if #(
    parameter int SYM_W = 10
);
    logic [SYM_W-1:0] symbol_i;
    logic             symbol_valid_i;
    logic             symbol_ready_o;

    modport master (
        output symbol_i,
        output symbol_valid_i,
        input  symbol_ready_o
    );

    modport slave (
        input  symbol_i,
        input  symbol_valid_i,
        output symbol_ready_o
    );
endinterface

// File: rtl/tx_symbol_serializer.sv
// Lane serializer: takes encoded symbols over a valid/ready handshake and
// shifts them out LSB-first, one bit per clock. A single holding register
// behind the shift register lets the encoder run one symbol ahead, so symbols
// delivered back-to-back leave the lane without gaps. If nothing is available
// at a symbol boundary the filler symbol is sent instead and counted.
module tx_symbol_serializer #(
    parameter int               SYM_W       = 10,
    parameter logic [SYM_W-1:0] IDLE_SYMBOL = 10'h17C,
    parameter int               CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tx_en_i,
    tx_symbol_serializer_if.slave sym_if,
    output logic                 tx_bit_o,
    output logic                 tx_bit_valid_o,
    output logic                 sym_start_o,
    output logic                 underrun_o,
    output logic [CNT_W-1:0]     underrun_cnt_o
);
    localparam int             BC_W     = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SYM_W - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [BC_W-1:0]  r_bit_cnt;
    logic [BC_W-1:0]  w_bit_cnt_next;
    logic [SYM_W-1:0] r_shift;
    logic [SYM_W-1:0] w_shift_next;
    logic [SYM_W-1:0] r_hold;
    logic [SYM_W-1:0] w_hold_next;
    logic             r_hold_full;
    logic             w_hold_full_next;
    logic             r_sym_start;
    logic             w_sym_start_next;
    logic             r_underrun;
    logic             w_underrun_next;
    logic [CNT_W-1:0] r_underrun_cnt;
    logic [CNT_W-1:0] w_underrun_cnt_next;

    logic             w_sym_end;
    logic             w_load;
    logic             w_ready;
    logic             w_accept;
    logic [SYM_W-1:0] w_load_sym;
    logic             w_filler;

    // The last bit of a symbol is on the lane; the next one is chosen now.
    assign w_sym_end = (r_state == ST_RUN) && (r_bit_cnt == LAST_BIT);
    // A new symbol enters the shift register when starting up, or at a
    // boundary while the lane stays enabled. A disabled boundary just stops.
    assign w_load    = tx_en_i && ((r_state == ST_IDLE) || w_sym_end);
    // On a load cycle the hold register is being emptied, so it can be
    // refilled in the same cycle even if it is currently full.
    assign w_ready   = !r_hold_full || w_load;
    assign w_accept  = sym_if.symbol_valid_i && w_ready;

    assign sym_if.symbol_ready_o = w_ready;

    // Next-state, symbol selection and hold-register bookkeeping.
    always_comb begin
        w_state_next        = r_state;
        w_bit_cnt_next      = r_bit_cnt;
        w_shift_next        = r_shift;
        w_hold_next         = r_hold;
        w_hold_full_next    = r_hold_full;
        w_sym_start_next    = 1'b0;
        w_underrun_next     = 1'b0;
        w_underrun_cnt_next = r_underrun_cnt;
        w_load_sym          = IDLE_SYMBOL;
        w_filler            = 1'b0;

        // Oldest data first: the held symbol beats a newly offered one,
        // which may only bypass the hold when the hold is empty.
        if (w_load) begin
            if (r_hold_full) begin
                w_load_sym       = r_hold;
                w_hold_full_next = w_accept;
                if (w_accept) begin
                    w_hold_next = sym_if.symbol_i;
                end
            end else if (w_accept) begin
                w_load_sym = sym_if.symbol_i;
            end else begin
                w_filler = 1'b1;
            end
        end else if (w_accept) begin
            w_hold_next      = sym_if.symbol_i;
            w_hold_full_next = 1'b1;
        end

        if (w_load) begin
            w_state_next     = ST_RUN;
            w_bit_cnt_next   = '0;
            w_shift_next     = w_load_sym;
            w_sym_start_next = 1'b1;
            w_underrun_next  = w_filler;
            if (w_filler && !(&r_underrun_cnt)) begin
                w_underrun_cnt_next = r_underrun_cnt + CNT_W'(1);
            end
        end else if (r_state == ST_RUN) begin
            if (w_sym_end) begin
                // Lane was disabled during this symbol: stop cleanly, keep hold.
                w_state_next   = ST_IDLE;
                w_bit_cnt_next = '0;
                w_shift_next   = '0;
            end else begin
                w_bit_cnt_next = r_bit_cnt + BC_W'(1);
                w_shift_next   = r_shift >> 1;
            end
        end
    end

    // State and datapath registers; reset discards any partial or held symbol.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_hold         <= '0;
            r_hold_full    <= 1'b0;
            r_sym_start    <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_state        <= w_state_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_shift        <= w_shift_next;
            r_hold         <= w_hold_next;
            r_hold_full    <= w_hold_full_next;
            r_sym_start    <= w_sym_start_next;
            r_underrun     <= w_underrun_next;
            r_underrun_cnt <= w_underrun_cnt_next;
        end
    end

    // The shift register is cleared whenever the lane is idle, so its LSB
    // doubles as the registered serial output.
    assign tx_bit_o       = r_shift[0];
    assign tx_bit_valid_o = (r_state == ST_RUN);
    assign sym_start_o    = r_sym_start;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_underrun_cnt;
endmodule

// File: tb/tb_tx_symbol_serializer.sv
// Bench for tx_symbol_serializer: a queue-based lane model checked every
// cycle, plus directed scenarios with hand-computed serial streams.
module tb_tx_symbol_serializer;
    localparam int         SYM_W = 10;
    localparam logic [9:0] IDLE  = 10'h17C;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    logic tx_en2;

    always #5 clk = ~clk;

    tx_symbol_serializer_if #(.SYM_W(SYM_W)) sif ();
    tx_symbol_serializer_if #(.SYM_W(SYM_W)) sif2 ();

    logic        tx_bit, tx_valid, sym_start, underrun;
    logic [15:0] ucnt;
    logic        tx_bit2, tx_valid2, sym_start2, underrun2;
    logic [1:0]  ucnt2;

    tx_symbol_serializer #(.SYM_W(SYM_W), .IDLE_SYMBOL(IDLE), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tx_en_i        (tx_en),
        .sym_if         (sif),
        .tx_bit_o       (tx_bit),
        .tx_bit_valid_o (tx_valid),
        .sym_start_o    (sym_start),
        .underrun_o     (underrun),
        .underrun_cnt_o (ucnt)
    );

    tx_symbol_serializer #(.SYM_W(SYM_W), .IDLE_SYMBOL(IDLE), .CNT_W(2)) dut2 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tx_en_i        (tx_en2),
        .sym_if         (sif2),
        .tx_bit_o       (tx_bit2),
        .tx_bit_valid_o (tx_valid2),
        .sym_start_o    (sym_start2),
        .underrun_o     (underrun2),
        .underrun_cnt_o (ucnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- lane model ----------------
    // Symbols accepted but not yet on the lane wait in a queue; at each
    // boundary the oldest one goes out, or the filler when the queue is empty.
    logic [9:0] m_pend[$];
    logic [9:0] m_cur   = '0;
    int         m_run   = 0;
    int         m_pos   = 0;
    int         m_total = 0;
    logic       m_ur    = 1'b0;
    logic       m_b, m_acc;

    function automatic logic m_boundary();
        return tx_en && (m_run == 0 || m_pos == SYM_W - 1);
    endfunction

    function automatic logic m_ready();
        return (m_pend.size() == 0) || m_boundary();
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend.delete();
            m_cur   = '0;
            m_run   = 0;
            m_pos   = 0;
            m_total = 0;
            m_ur    = 1'b0;
        end else begin
            m_b   = m_boundary();
            m_acc = sif.symbol_valid_i && m_ready();
            if (m_acc) m_pend.push_back(sif.symbol_i);
            m_ur = 1'b0;
            if (m_b) begin
                if (m_pend.size() > 0) begin
                    m_cur = m_pend.pop_front();
                end else begin
                    m_cur = IDLE;
                    m_ur  = 1'b1;
                    m_total++;
                end
                m_run = 1;
                m_pos = 0;
            end else if (m_run != 0) begin
                if (m_pos == SYM_W - 1) m_run = 0;
                else m_pos++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", tx_valid, 0);
            check("rst_bit", tx_bit, 0);
            check("rst_start", sym_start, 0);
            check("rst_underrun", underrun, 0);
            check("rst_cnt", ucnt, 0);
            check("rst_ready", sif.symbol_ready_o, 1);
        end else begin
            check("valid", tx_valid, (m_run != 0));
            check("bit", tx_bit, (m_run != 0) ? m_cur[m_pos] : 1'b0);
            check("start", sym_start, (m_run != 0) && (m_pos == 0));
            check("underrun", underrun, m_ur);
            check("cnt", ucnt, (m_total > 65535) ? 65535 : m_total);
            check("ready", sif.symbol_ready_o, m_ready());
        end
    end

    // ---------------- capture of the live lane ----------------
    logic cap_bit[$];
    logic cap_start[$];
    logic cap_ur[$];
    int   ur2_pulses = 0;

    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            cap_bit.push_back(tx_bit);
            cap_start.push_back(sym_start);
            cap_ur.push_back(underrun);
        end
        if (rst_n && underrun2) ur2_pulses++;
    end

    function automatic logic [9:0] qword(input int off);
        logic [9:0] w = '0;
        for (int i = 0; i < 10; i++)
            if (off + i < cap_bit.size()) w[i] = cap_bit[off + i];
        return w;
    endfunction

    function automatic int sum_ur(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi && i < cap_ur.size(); i++) s += int'(cap_ur[i]);
        return s;
    endfunction

    function automatic int sum_start(input int lo, input int hi);
        int s = 0;
        for (int i = lo; i < hi && i < cap_start.size(); i++) s += int'(cap_start[i]);
        return s;
    endfunction

    task automatic clear_cap();
        cap_bit.delete();
        cap_start.delete();
        cap_ur.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers a symbol and returns once it has been accepted; reports how
    // many cycles ready was low first.
    task automatic send(input logic [9:0] s, output int waits);
        sif.symbol_i       = s;
        sif.symbol_valid_i = 1'b1;
        waits = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (sif.symbol_ready_o) break;
            waits++;
        end
        check("send_accept", sif.symbol_ready_o, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!tx_valid) break;
        end
        check("idle_reached", tx_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        tx_en = 1'b0;
        tx_en2 = 1'b0;
        sif.symbol_i = '0;
        sif.symbol_valid_i = 1'b0;
        sif2.symbol_i = '0;
        sif2.symbol_valid_i = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Back-to-back 0x17C, 0x283: 20 gapless bits, starts at 0 and 10.
        clear_cap();
        tx_en = 1'b1;
        send(10'h17C, w);
        send(10'h283, w);
        sif.symbol_valid_i = 1'b0;
        tick(20);
        tx_en = 1'b0;
        wait_idle();
        check("b2b_len", cap_bit.size() >= 20, 1);
        check("b2b_sym0", qword(0), 10'h17C);
        check("b2b_sym1", qword(10), 10'h283);
        check("b2b_start0", cap_start[0], 1);
        check("b2b_start10", cap_start[10], 1);
        check("b2b_nstart", sum_start(0, 20), 2);
        check("b2b_nounderrun", sum_ur(0, 20), 0);

        // Pure underrun for 30 cycles after a fresh reset.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_cap();
        tx_en = 1'b1;
        tick(30);
        tx_en = 1'b0;
        wait_idle();
        check("ur_len", cap_bit.size(), 30);
        check("ur_sym0", qword(0), 10'h17C);
        check("ur_sym1", qword(10), 10'h17C);
        check("ur_sym2", qword(20), 10'h17C);
        check("ur_pulses", sum_ur(0, 30), 3);
        check("ur_starts", sum_start(0, 30), 3);
        check("ur_cnt", ucnt, 3);

        // Backpressure: third symbol waits 8 cycles for the boundary.
        clear_cap();
        tx_en = 1'b1;
        send(10'h001, w);
        send(10'h002, w);
        check("bp_wait2", w, 0);
        send(10'h003, w);
        check("bp_wait3", w, 8);
        sif.symbol_valid_i = 1'b0;
        tick(15);
        tx_en = 1'b0;
        wait_idle();
        check("bp_len", cap_bit.size(), 30);
        check("bp_sym0", qword(0), 10'h001);
        check("bp_sym1", qword(10), 10'h002);
        check("bp_sym2", qword(20), 10'h003);
        check("bp_nounderrun", sum_ur(0, 30), 0);

        // Disable at bit 4 of 0x3FF with 0x155 held; 0x155 follows on re-enable.
        clear_cap();
        send(10'h3FF, w);
        tx_en = 1'b1;
        send(10'h155, w);
        sif.symbol_valid_i = 1'b0;
        tick(4);
        tx_en = 1'b0;
        tick(8);
        check("dis_len", cap_bit.size(), 10);
        check("dis_sym", qword(0), 10'h3FF);
        check("dis_hold_ready", sif.symbol_ready_o, 0);
        tx_en = 1'b1;
        tick(1);
        tx_en = 1'b0;
        wait_idle();
        check("dis_len2", cap_bit.size(), 20);
        check("dis_held", qword(10), 10'h155);
        check("dis_start", cap_start[10], 1);
        check("dis_nounderrun", sum_ur(0, 20), 0);

        // Reset during bit 5 of 0x2A5 with 0x0AA held: everything discarded.
        clear_cap();
        tx_en = 1'b1;
        send(10'h2A5, w);
        send(10'h0AA, w);
        sif.symbol_valid_i = 1'b0;
        tick(4);
        rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        check("rm_valid", tx_valid, 0);
        check("rm_ready", sif.symbol_ready_o, 1);
        check("rm_cnt", ucnt, 0);
        check("rm_partial", qword(0) & 10'h01F, 10'h2A5 & 10'h01F);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_cap();
        tx_en = 1'b1;
        tick(10);
        check("rm_first_idle", qword(0), 10'h17C);
        check("rm_cnt1", ucnt, 1);
        check("rm_pulse", sum_ur(0, 10), 1);
        tx_en = 1'b0;
        wait_idle();

        // Two-bit counter saturates at 3 while pulses keep coming.
        ur2_pulses = 0;
        tx_en2 = 1'b1;
        tick(15);
        check("sat_cnt2", ucnt2, 2);
        tick(35);
        tx_en2 = 1'b0;
        tick(12);
        check("sat_cnt", ucnt2, 3);
        check("sat_pulses", ur2_pulses, 5);
        check("sat_idle", tx_valid2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
